// File: rtl/exec_pipe.sv
// Pipelined tenyr execute unit: Z = f(A,B) + C, with the tag carried alongside each op.
// Latency: STAGES edges from acceptance to out_valid (op/operand, f(A,B), +C, then pure delay).
// Backpressure: per-stage valid/ready, so bubbles collapse; in_ready is low only when full and stalled, or on flush/reset.
module exec_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAGW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAGW-1:0]  out_tag,
    output logic             busy
);

    localparam int NRES = STAGES - 2;
    localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        logic [TAGW-1:0]  tag;
    } opnd_t;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] c;
        logic [TAGW-1:0]  tag;
    } part_t;

    typedef struct packed {
        logic [WIDTH-1:0] z;
        logic [TAGW-1:0]  tag;
    } res_t;

    logic [STAGES-1:0]       vld_q, vld_d, load;
    logic                    chain_rdy;
    logic                    in_fire;
    opnd_t                   s1_q, s1_d;
    part_t                   s2_q, s2_d;
    res_t [NRES-1:0]         res_q, res_d;

    logic [WIDTH-1:0]        op_a, op_b, y_d, srl_v;
    logic signed [WIDTH-1:0] sra_v;
    logic                    shift_big;

    // Ready ripples back from the consumer: a stage can load if it is empty or everything after it can move.
    always_comb begin
        load      = '0;
        chain_rdy = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain_rdy = !vld_q[k] || chain_rdy;
            load[k]   = chain_rdy;
        end
    end

    assign in_ready = load[0] && !flush && !reset;
    assign in_fire  = in_valid && in_ready;

    assign op_a      = s1_q.a;
    assign op_b      = s1_q.b;
    assign shift_big = (op_b >= W_LIM);
    assign srl_v     = shift_big ? '0 : (op_a >> op_b);
    assign sra_v     = $signed(op_a) >>> op_b;

    always_comb begin
        y_d = '0;
        case (s1_q.op)
            4'h0: y_d = op_a | op_b;
            4'h1: y_d = op_a & op_b;
            4'h2: y_d = op_a ^ op_b;
            4'h3: y_d = shift_big ? {WIDTH{op_a[WIDTH-1]}} : sra_v;
            4'h4: y_d = op_a + op_b;
            4'h5: y_d = op_a * op_b;
            4'h6: y_d = {WIDTH{op_a == op_b}};
            4'h7: y_d = {WIDTH{$signed(op_a) < $signed(op_b)}};
            4'h8: y_d = op_a | ~op_b;
            4'h9: y_d = op_a & ~op_b;
            4'ha: y_d = {op_a[WIDTH-13:0], op_b[11:0]};
            4'hb: y_d = srl_v;
            4'hc: y_d = op_a - op_b;
            4'hd: y_d = shift_big ? '0 : (op_a << op_b);
            4'he: y_d = {WIDTH{srl_v[0]}};
            4'hf: y_d = {WIDTH{$signed(op_a) >= $signed(op_b)}};
            default: y_d = '0;
        endcase
    end

    always_comb begin
        vld_d = vld_q;
        s1_d  = s1_q;
        s2_d  = s2_q;
        res_d = res_q;

        if (load[0]) begin
            vld_d[0] = in_fire;
            if (in_fire) begin
                s1_d.op  = in_op;
                s1_d.a   = in_a;
                s1_d.b   = in_b;
                s1_d.c   = in_c;
                s1_d.tag = in_tag;
            end
        end

        if (load[1]) begin
            vld_d[1] = vld_q[0];
            if (vld_q[0]) begin
                s2_d.y   = y_d;
                s2_d.c   = s1_q.c;
                s2_d.tag = s1_q.tag;
            end
        end

        if (load[2]) begin
            vld_d[2] = vld_q[1];
            if (vld_q[1]) begin
                res_d[0].z   = s2_q.y + s2_q.c;
                res_d[0].tag = s2_q.tag;
            end
        end

        // Delay stages only move data that is actually present, so a stalled tail holds steady.
        for (int k = 3; k < STAGES; k++) begin
            if (load[k]) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    res_d[k-2] = res_q[k-3];
                end
            end
        end

        if (flush) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
            res_q <= '0;
        end else begin
            vld_q <= vld_d;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            res_q <= res_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_data  = res_q[NRES-1].z;
    assign out_tag   = res_q[NRES-1].tag;
    assign busy      = |vld_q;

endmodule

// File: tb/tb_exec_pipe.sv
// Bench for exec_pipe: directed vector table, handshake sequences, and randomized traffic against a queue-based model.
module tb_exec_pipe;

    localparam int W  = 32;
    localparam int S  = 3;
    localparam int NV = 19;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0]   in_op, in_tag, out_tag;
    logic [W-1:0] in_a, in_b, in_c, out_data;

    logic         v5_in_valid, v5_in_ready, v5_out_valid, v5_out_ready, v5_busy;
    logic [3:0]   v5_in_op, v5_in_tag, v5_out_tag;
    logic [15:0]  v5_in_a, v5_in_b, v5_in_c, v5_out_data;

    exec_pipe #(.WIDTH(W), .STAGES(S), .TAGW(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .busy(busy)
    );

    exec_pipe #(.WIDTH(16), .STAGES(5), .TAGW(4)) dut5 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(v5_in_valid), .in_ready(v5_in_ready), .in_op(v5_in_op),
        .in_a(v5_in_a), .in_b(v5_in_b), .in_c(v5_in_c), .in_tag(v5_in_tag),
        .out_valid(v5_out_valid), .out_ready(v5_out_ready),
        .out_data(v5_out_data), .out_tag(v5_out_tag), .busy(v5_busy)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
    } exp_t;

    vec_t        vecs[NV];
    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    bit          stalled = 1'b0;
    logic [31:0] held_d;
    logic [3:0]  held_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference semantics computed on 64-bit integers and masked to width w.
    function automatic logic [63:0] ref_z(input int w, input logic [3:0] op,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c);
        logic [63:0] m, y;
        longint      sa, sb, sh;
        logic        big;
        m   = (64'd1 << w) - 64'd1;
        sa  = a[w-1] ? longint'(a | ~m) : longint'(a & m);
        sb  = b[w-1] ? longint'(b | ~m) : longint'(b & m);
        big = (b >= 64'(w));
        sh  = (sa < 0) ? -64'sd1 : 64'sd0;
        if (!big) sh = sa >>> b;
        y = 64'd0;
        case (op)
            4'h0: y = a | b;
            4'h1: y = a & b;
            4'h2: y = a ^ b;
            4'h3: y = 64'(sh);
            4'h4: y = a + b;
            4'h5: y = a * b;
            4'h6: y = ((a & m) == (b & m)) ? '1 : '0;
            4'h7: y = (sa < sb) ? '1 : '0;
            4'h8: y = a | ~b;
            4'h9: y = a & ~b;
            4'ha: y = ((a & ((64'd1 << (w - 12)) - 64'd1)) << 12) | (b & 64'hFFF);
            4'hb: y = big ? 64'd0 : ((a & m) >> b);
            4'hc: y = a - b;
            4'hd: y = big ? 64'd0 : (a << b);
            4'he: y = (!big && ((((a & m) >> b) & 64'd1) != 64'd0)) ? '1 : '0;
            4'hf: y = (sa >= sb) ? '1 : '0;
            default: y = 64'd0;
        endcase
        return (y + c) & m;
    endfunction

    // One bus cycle: drive at negedge, check against the model, and account for fires at the coming edge.
    task automatic step(input bit v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input logic [3:0] tag,
                        input bit ordy, input bit fl,
                        output bit acc, output bit dlv, output logic [3:0] dtag);
        exp_t        e;
        logic [63:0] z64;
        @(negedge clk);
        in_valid = v; in_op = op; in_a = a; in_b = b; in_c = c; in_tag = tag;
        out_ready = ordy; flush = fl;
        #1;
        acc = 1'b0; dlv = 1'b0; dtag = '0;
        chk("in_ready", in_ready, !fl && !(sbq.size() == S && !ordy));
        chk("busy", busy, sbq.size() != 0);
        if (stalled) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, held_d);
            chk("stall_tag", out_tag, held_t);
        end
        if (out_valid) begin
            if (sbq.size() == 0) begin
                chk("spurious_out_valid", out_valid, 0);
            end else begin
                chk("out_data", out_data, sbq[0].d);
                chk("out_tag", out_tag, sbq[0].t);
            end
        end
        stalled = out_valid && !ordy && !fl;
        held_d  = out_data;
        held_t  = out_tag;
        if (out_valid && ordy && !fl && sbq.size() != 0) begin
            dlv  = 1'b1;
            dtag = sbq[0].t;
            void'(sbq.pop_front());
        end
        if (v && in_ready) begin
            acc = 1'b1;
            z64 = ref_z(W, op, {32'd0, a}, {32'd0, b}, {32'd0, c});
            e.d = z64[31:0];
            e.t = tag;
            sbq.push_back(e);
        end
        if (fl) sbq.delete();
    endtask

    task automatic run_vec(input vec_t v, input logic [3:0] tag);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_op = v.op; in_a = v.a; in_b = v.b; in_c = v.c; in_tag = tag;
        out_ready = 1'b1; flush = 1'b0;
        #1 chk({v.nm, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({v.nm, "_latency"}, lat, S);
        chk({v.nm, "_data"}, out_data, v.exp);
        chk({v.nm, "_tag"}, out_tag, tag);
    endtask

    initial begin
        bit          acc, dlv;
        logic [3:0]  dtag;
        int          nxt, ndlv, exp_tag, lat;
        bit          seen;

        vecs[0]  = '{op: 4'h4, a: 32'd5,        b: 32'd7,        c: 32'd1, exp: 32'h0000000D, nm: "add"};
        vecs[1]  = '{op: 4'h7, a: 32'hFFFFFFFF, b: 32'd0,        c: 32'd0, exp: 32'hFFFFFFFF, nm: "lt"};
        vecs[2]  = '{op: 4'hf, a: 32'hFFFFFFFF, b: 32'd0,        c: 32'd0, exp: 32'h00000000, nm: "ge"};
        vecs[3]  = '{op: 4'h6, a: 32'd9,        b: 32'd9,        c: 32'd2, exp: 32'h00000001, nm: "eq"};
        vecs[4]  = '{op: 4'ha, a: 32'h00012345, b: 32'h00000ABC, c: 32'd0, exp: 32'h12345ABC, nm: "pack"};
        vecs[5]  = '{op: 4'h3, a: 32'h80000000, b: 32'd40,       c: 32'd0, exp: 32'hFFFFFFFF, nm: "sra_big"};
        vecs[6]  = '{op: 4'hb, a: 32'h80000000, b: 32'd40,       c: 32'd0, exp: 32'h00000000, nm: "srl_big"};
        vecs[7]  = '{op: 4'he, a: 32'h80000000, b: 32'd31,       c: 32'd0, exp: 32'hFFFFFFFF, nm: "bit31"};
        vecs[8]  = '{op: 4'h3, a: 32'h80000000, b: 32'd4,        c: 32'd0, exp: 32'hF8000000, nm: "sra4"};
        vecs[9]  = '{op: 4'hd, a: 32'd1,        b: 32'd4,        c: 32'd0, exp: 32'h00000010, nm: "sll4"};
        vecs[10] = '{op: 4'h5, a: 32'hFFFFFFFD, b: 32'd7,        c: 32'd1, exp: 32'hFFFFFFEC, nm: "mul"};
        vecs[11] = '{op: 4'hc, a: 32'd5,        b: 32'd7,        c: 32'd0, exp: 32'hFFFFFFFE, nm: "sub"};
        vecs[12] = '{op: 4'h8, a: 32'd0,        b: 32'hFFFF0000, c: 32'd0, exp: 32'h0000FFFF, nm: "orn"};
        vecs[13] = '{op: 4'h9, a: 32'hFFFFFFFF, b: 32'h0000000F, c: 32'd0, exp: 32'hFFFFFFF0, nm: "andn"};
        vecs[14] = '{op: 4'h0, a: 32'hF0,       b: 32'h0F,       c: 32'd0, exp: 32'h000000FF, nm: "or"};
        vecs[15] = '{op: 4'h2, a: 32'hFF,       b: 32'h0F,       c: 32'd0, exp: 32'h000000F0, nm: "xor"};
        vecs[16] = '{op: 4'h1, a: 32'hFF,       b: 32'h0F,       c: 32'd0, exp: 32'h0000000F, nm: "and"};
        vecs[17] = '{op: 4'h4, a: 32'h7FFFFFFF, b: 32'd1,        c: 32'd0, exp: 32'h80000000, nm: "add_wrap"};
        vecs[18] = '{op: 4'hd, a: 32'd1,        b: 32'd32,       c: 32'd0, exp: 32'h00000000, nm: "sll_big"};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_op = '0; in_a = '0; in_b = '0; in_c = '0; in_tag = '0;
        v5_in_valid = 1'b0; v5_out_ready = 1'b1; v5_in_op = '0;
        v5_in_a = '0; v5_in_b = '0; v5_in_c = '0; v5_in_tag = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy5", v5_busy, 0);
        in_valid = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], 4'(i));

        // Six back-to-back adds with a four-cycle consumer stall in the middle.
        stalled = 1'b0; nxt = 0; ndlv = 0; exp_tag = 0;
        for (int cyc = 0; cyc < 40 && (nxt < 6 || sbq.size() > 0); cyc++) begin
            step(nxt < 6, 4'h4, 32'(100 + nxt), 32'(nxt), 32'd1, 4'(nxt),
                 !(cyc >= 3 && cyc < 7), 1'b0, acc, dlv, dtag);
            if (acc) nxt++;
            if (dlv) begin
                chk("bp_order", dtag, 4'(exp_tag));
                exp_tag++;
                ndlv++;
            end
        end
        chk("bp_accepted", nxt, 6);
        chk("bp_delivered", ndlv, 6);

        // Flush with three in flight and a competing input tagged 7.
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 4'h4, 32'(i), 32'd1, 32'd0, 4'(i), 1'b0, 1'b0, acc, dlv, dtag);
            chk("flush_fill_acc", acc, 1);
        end
        step(1'b1, 4'h4, 32'd70, 32'd7, 32'd0, 4'd7, 1'b1, 1'b1, acc, dlv, dtag);
        chk("flush_tag7_rejected", acc, 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        stalled = 1'b0;
        step(1'b1, 4'h4, 32'd9, 32'd9, 32'd0, 4'd9, 1'b1, 1'b0, acc, dlv, dtag);
        chk("post_flush_acc", acc, 1);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(1'b0, 4'h0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, acc, dlv, dtag);
            if (dlv) begin
                seen = 1'b1;
                chk("post_flush_first_tag", dtag, 9);
            end
        end
        chk("post_flush_seen", seen, 1);

        // Randomized traffic with random stalls and occasional flushes.
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [31:0] rb;
            rb = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), $urandom, rb, $urandom,
                 4'($urandom_range(0, 15)), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 49) == 0, acc, dlv, dtag);
        end
        for (int k = 0; k < 20 && sbq.size() > 0; k++)
            step(1'b0, 4'h0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, acc, dlv, dtag);
        chk("rand_drained", sbq.size(), 0);

        // Asynchronous reset between edges with a result waiting at the output.
        for (int i = 0; i < 4; i++)
            step(i < 3, 4'h4, 32'd5, 32'd7, 32'd1, 4'(i), 1'b0, 1'b0, acc, dlv, dtag);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("pre_reset_valid", out_valid, 1);
        #1 reset = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_tag", out_tag, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        sbq.delete();
        stalled = 1'b0;

        // Deeper, narrower instance: same add, five-edge latency.
        @(negedge clk);
        v5_in_valid = 1'b1; v5_in_op = 4'h4; v5_in_a = 16'd5; v5_in_b = 16'd7;
        v5_in_c = 16'd1; v5_in_tag = 4'd3; v5_out_ready = 1'b1;
        #1 chk("d5_in_ready", v5_in_ready, 1);
        @(negedge clk);
        v5_in_valid = 1'b0;
        lat = 1;
        while (!v5_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("d5_latency", lat, 5);
        chk("d5_data", v5_out_data, 16'h000D);
        chk("d5_tag", v5_out_tag, 3);
        @(negedge clk);
        chk("d5_drained_busy", v5_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_pipe.md
Name: exec_pipe

Overview:
- Parametrised successor to the core's fixed four-stage execute unit.
- Computes Z = f(A,B) + C for the 16-entry tenyr op set at configurable data width and pipeline depth.
- Adds valid/ready handshakes on both sides with bubble collapsing, tag passthrough, flush and a busy flag.
- Sits between operand shuffle and register writeback; replaces the en/done strobe pair so the core can overlap fetch with execute.

Parameters:
WIDTH, 32, datapath width in bits; legal range 16..64.
STAGES, 3, total pipeline depth; minimum 3, stages beyond 3 are pure delay stages appended after the add stage.
TAGW, 4, width of the sideband tag carried alongside each operation.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous; discards every in-flight operation
in_valid  input  1  operation presented
in_ready  output  1  operation accepted when in_valid && in_ready at a clock edge
in_op  input  4  operation code
in_a  input  WIDTH  operand A, signed
in_b  input  WIDTH  operand B, signed
in_c  input  WIDTH  addend C, signed
in_tag  input  TAGW  sideband, returned unchanged with the result
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result when out_valid && out_ready at a clock edge
out_data  output  WIDTH  result Z
out_tag  output  TAGW  tag of the result
busy  output  1  OR of all stage valid bits

Behaviour:
- Reset (asynchronous, takes effect without a clock edge):
  - All stage valid bits and registered data clear.
  - out_valid=0, out_data=0, out_tag=0, busy=0.
  - in_ready=0 while reset is high, then follows the rules below.
- Stage structure:
  - S1 registers op, A, B, C and tag.
  - S2 registers Y=f(A,B), C and tag.
  - S3 registers Y+C, truncated to WIDTH with wrap and no overflow flag.
  - S4..S[STAGES] are delay stages.
  - out_* are driven directly from the last stage.
- Op set (A, B, C signed):
  - 0: A|B; 1: A&B; 2: A^B.
  - 3: A>>>B; b: A>>B; d: A<<B. The shift amount is the full unsigned value of B; if B>=WIDTH the result is 0 for logical shifts and all-sign for the arithmetic shift.
  - 4: A+B; 5: A*B (low WIDTH bits); c: A-B.
  - 6: all-ones if A==B, else 0; 7: all-ones if A<B, else 0; f: all-ones if A>=B, else 0.
  - 8: A|~B; 9: A&~B.
  - a: {A[WIDTH-13:0], B[11:0]}.
  - e: bit 0 of (A>>B), logical shift, replicated to WIDTH.
- Handshake and flow control:
  - Stage k loads when it is empty, or when its current contents leave in the same cycle.
  - The last stage leaves on out_ready. Readiness propagates combinationally from out_ready back to in_ready.
  - Bubbles collapse: a stalled output does not block acceptance while any earlier stage is empty.
  - Full throughput: one operation accepted per cycle when out_ready is held high.
  - Latency is STAGES edges from acceptance to out_valid, with no stall.
  - in_ready=0 only when every stage is valid and out_ready=0, or when flush=1.
  - out_data and out_tag are held stable while out_valid && !out_ready.
- Ordering: results are delivered strictly in acceptance order, with no drop or duplication except on flush.
- Flush:
  - At the edge where flush=1, all valid bits clear and out_valid=0 from the next cycle.
  - Any input presented in that cycle is not accepted, because in_ready is forced to 0.
  - flush and out_ready in the same cycle: the output is considered consumed. The consumer must ignore any result it sampled that cycle.
- busy is combinational from the valid bits and is 0 exactly when the pipeline is empty.

Test Plan:
- Add: WIDTH=32, STAGES=3, op 4, A=5, B=7, C=1, tag=3. Required: out_valid on the 3rd edge after acceptance, out_data=0x0000000D, out_tag=3.
- Compare ops: op 7 with A=0xFFFFFFFF, B=0, C=0 -> 0xFFFFFFFF. Op f with the same operands -> 0. Op 6 with A=B=9, C=2 -> 0x00000001.
- Pack and shift:
  - Op a, A=0x00012345, B=0x00000ABC -> 0x12345ABC.
  - A=0x80000000, B=40: op 3 -> 0xFFFFFFFF; op b -> 0; op e with B=31 -> 0xFFFFFFFF.
- Backpressure: 6 back-to-back adds with tags 0..5, out_ready low for 4 cycles mid-stream. Required:
  - Results arrive in tag order 0..5 with no loss or duplicates.
  - in_ready falls only once 3 stages are full.
  - out_data is stable while stalled.
- Flush: 3 ops in flight, flush for 1 cycle alongside an input with tag 7. Required:
  - out_valid=0 and busy=0 the next cycle.
  - Tag 7 is not accepted.
  - The next op accepted after flush is the first result seen.
- Reset and depth: reset asserted mid-stream between clock edges -> out_valid, out_data and busy are 0 immediately. Repeat the add test with STAGES=5, WIDTH=16 -> latency 5, result 0x000D.
